// File: rtl/instr_fetch_ctrl_if.sv
// ============================================================================
// instr_fetch_ctrl_if
// Bundles the fetch controller's handshake and bus signals.
//
//   stall          : hazard hold from the pipeline
//   redirect_valid : branch/jump taken this cycle
//   redirect_pc    : byte address of the branch/jump target
//   imem_addr      : byte address presented to instruction memory
//   imem_instr     : instruction word returned for imem_addr
//   ifid_instr     : registered fetched instruction
//   ifid_pc4       : registered PC+4 of ifid_instr
//   ifid_valid     : ifid_instr is a real instruction (0 = bubble)
//   halted         : controller sits in its HALT state
//   fetch_count    : saturating fetch counter (FETCH_PERF_EN only)
//   stall_count    : saturating stall counter (FETCH_PERF_EN only)
//
// Modports: master = the fetch controller, slave = pipeline/memory side.
// Optional macro: FETCH_PERF_EN adds the two performance counters.
// ============================================================================
interface instr_fetch_ctrl_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_instr,
`ifdef FETCH_PERF_EN
        output fetch_count, stall_count,
`endif
        output imem_addr, ifid_instr, ifid_pc4, ifid_valid, halted
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_instr,
`ifdef FETCH_PERF_EN
        input  fetch_count, stall_count,
`endif
        input  imem_addr, ifid_instr, ifid_pc4, ifid_valid, halted
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// ============================================================================
// instr_fetch_ctrl
// Instruction-fetch controller: owns the PC, drives instruction memory and
// registers the fetched word into the IF/ID stage. Handles stalls, branch
// redirects (with target legality check) and halts when fetch runs off the
// end of instruction memory or a redirect points somewhere illegal.
//
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : instr_fetch_ctrl_if.master (stall/redirect in, imem and IF/ID out)
//
// Parameters:
//   RESET_PC   : word-aligned PC loaded on reset
//   IMEM_WORDS : instruction memory depth in 32-bit words
//
// Optional macro: FETCH_PERF_EN adds saturating fetch_count/stall_count.
// ============================================================================
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instr_fetch_ctrl_if.master        bus
);

    localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] ifidInstr_q;
    logic [31:0] ifidPc4_q;
    logic        ifidValid_q;
    logic        halted_q;
`ifdef FETCH_PERF_EN
    logic [31:0] fetchCount_q;
    logic [31:0] stallCount_q;
`endif

    logic [31:0] pcPlus4_d;
    logic        redirectLegal_d;

    // Sequential successor of the PC and the legality test for a redirect
    // target: it must be word aligned and land inside instruction memory.
    assign pcPlus4_d       = pc_q + 32'd4;
    assign redirectLegal_d = (bus.redirect_pc[1:0] == 2'b00) &&
                             (bus.redirect_pc < IMEM_BYTES);

    // Memory is addressed straight from the PC so the word comes back in
    // the same cycle and can be captured at the next edge.
    assign bus.imem_addr  = pc_q;
    assign bus.ifid_instr = ifidInstr_q;
    assign bus.ifid_pc4   = ifidPc4_q;
    assign bus.ifid_valid = ifidValid_q;
    assign bus.halted     = halted_q;
`ifdef FETCH_PERF_EN
    assign bus.fetch_count = fetchCount_q;
    assign bus.stall_count = stallCount_q;
`endif

    // Main controller. IDLE gives one quiet cycle after reset. In RUN and
    // HALT a redirect beats everything, including stall. When the fetch of
    // the last memory word completes, the PC is frozen on that word rather
    // than stepping past the end, so PC arithmetic can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            ifidInstr_q  <= 32'd0;
            ifidPc4_q    <= 32'd0;
            ifidValid_q  <= 1'b0;
            halted_q     <= 1'b0;
`ifdef FETCH_PERF_EN
            fetchCount_q <= 32'd0;
            stallCount_q <= 32'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_q     <= RUN;
                    ifidValid_q <= 1'b0;
                    halted_q    <= 1'b0;
                end
                RUN, HALT: begin
                    if (bus.redirect_valid) begin
                        ifidValid_q <= 1'b0;
                        if (redirectLegal_d) begin
                            pc_q     <= bus.redirect_pc;
                            state_q  <= RUN;
                            halted_q <= 1'b0;
                        end else begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end
                    end else if (state_q == RUN) begin
                        if (bus.stall) begin
`ifdef FETCH_PERF_EN
                            if (stallCount_q != 32'hFFFF_FFFF)
                                stallCount_q <= stallCount_q + 32'd1;
`endif
                        end else begin
                            ifidInstr_q <= bus.imem_instr;
                            ifidPc4_q   <= pcPlus4_d;
                            ifidValid_q <= 1'b1;
`ifdef FETCH_PERF_EN
                            if (fetchCount_q != 32'hFFFF_FFFF)
                                fetchCount_q <= fetchCount_q + 32'd1;
`endif
                            if (pcPlus4_d == IMEM_BYTES) begin
                                state_q  <= HALT;
                                halted_q <= 1'b1;
                            end else begin
                                pc_q <= pcPlus4_d;
                            end
                        end
                    end else begin
                        // HALT without redirect: drain the last word once.
                        if (!bus.stall)
                            ifidValid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    ifidValid_q <= 1'b0;
                    halted_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule
